// File: rtl/adc_sample_conditioner.sv
// adc_sample_conditioner: ADC word conversion, offset removal, power-of-two boxcar decimation and output FIFO
module adc_sample_conditioner #(
  parameter int DEC_MAX_LOG2 = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        adc_clk,
  input  logic        adc_rstn,
  input  logic [13:0] adc_dat_i,
  input  logic        adc_vld_i,
  input  logic        cfg_en,
  input  logic [3:0]  cfg_log2_dec,
  input  logic [15:0] cfg_offset,
  output logic [15:0] m_dat_o,
  output logic        m_vld_o,
  input  logic        m_rdy_i,
  output logic [15:0] drop_cnt_o
);
  localparam int AW = 16 + DEC_MAX_LOG2;
  localparam int CW = DEC_MAX_LOG2 + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LMAX = 4'(DEC_MAX_LOG2);
  typedef enum logic {IDLE, ACC} state_t;
  state_t state_q;
  logic [3:0] l_q, l_d;
  logic signed [AW-1:0] acc_q, sum_d;
  logic [CW-1:0] cnt_q;
  logic s1_vld_q;
  logic [15:0] s1_dat_q, sat_d, res_d;
  logic [16:0] y_d;
  logic last_d, push_d, pop_d, wr_en_d, full_d, empty_d;
  logic [15:0] mem_q [FIFO_DEPTH];
  logic [PW:0] wr_q, rd_q;
  logic [15:0] drop_q;
  always_comb begin
    y_d = {{4{adc_dat_i[13]}}, ~adc_dat_i[12:0]} - {cfg_offset[15], cfg_offset};
    sat_d = (y_d[16] ^ y_d[15]) ? (y_d[16] ? 16'h8000 : 16'h7fff) : y_d[15:0];
    l_d = (cfg_log2_dec > LMAX) ? LMAX : cfg_log2_dec;
    sum_d = acc_q + {{DEC_MAX_LOG2{s1_dat_q[15]}}, s1_dat_q};
    last_d = cnt_q == ((CW'(1) << l_q) - CW'(1));
    res_d = 16'(sum_d >>> l_q);
    push_d = state_q == ACC && cfg_en && s1_vld_q && last_d;
    empty_d = wr_q == rd_q;
    full_d = wr_q == {~rd_q[PW], rd_q[PW-1:0]};
    pop_d = !empty_d && m_rdy_i;
    wr_en_d = push_d && (!full_d || pop_d);
  end
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      state_q <= IDLE;
      l_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
    end else begin
      s1_vld_q <= cfg_en && adc_vld_i;
      if (cfg_en && adc_vld_i) s1_dat_q <= sat_d;
      if (!cfg_en) begin
        state_q <= IDLE;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state_q == IDLE) begin
        state_q <= ACC;
        l_q <= l_d;
      end else if (s1_vld_q) begin
        acc_q <= last_d ? '0 : sum_d;
        cnt_q <= last_d ? '0 : cnt_q + CW'(1);
        if (last_d) l_q <= l_d;
      end
    end
  end
  // a full FIFO popped this cycle frees the slot the write lands in
  always_ff @(posedge adc_clk) begin
    if (wr_en_d) mem_q[wr_q[PW-1:0]] <= res_d;
  end
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      wr_q <= '0;
      rd_q <= '0;
      drop_q <= '0;
    end else begin
      if (wr_en_d) wr_q <= wr_q + (PW+1)'(1);
      if (pop_d) rd_q <= rd_q + (PW+1)'(1);
      if (push_d && !wr_en_d && drop_q != 16'hffff) drop_q <= drop_q + 16'd1;
    end
  end
  assign m_vld_o = !empty_d;
  assign m_dat_o = empty_d ? '0 : mem_q[rd_q[PW-1:0]];
  assign drop_cnt_o = drop_q;
endmodule
